// File: rtl/cp0_pkg.sv
// CP0 register numbers, ExcCode values, field positions and sequencer states
// shared by the exception controller and its priority encoder.
package cp0_pkg;

  localparam logic [4:0] CP0_STATUS = 5'd12;
  localparam logic [4:0] CP0_CAUSE  = 5'd13;
  localparam logic [4:0] CP0_EPC    = 5'd14;

  localparam logic [4:0] EXC_INT = 5'd0;
  localparam logic [4:0] EXC_SYS = 5'd8;
  localparam logic [4:0] EXC_BP  = 5'd9;
  localparam logic [4:0] EXC_RI  = 5'd10;
  localparam logic [4:0] EXC_OV  = 5'd12;
  localparam logic [4:0] EXC_DZ  = 5'd13;

  localparam int ST_IE     = 0;
  localparam int ST_EXL    = 1;
  localparam int ST_IM_LO  = 8;
  localparam int CA_EXC_LO = 2;
  localparam int CA_IP_LO  = 10;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    FLUSH  = 2'd1,
    VECTOR = 2'd2,
    RETURN = 2'd3
  } cp0_state_e;

endpackage

// File: rtl/exc_prio_enc.sv
// Combinational trap arbiter: fixed-priority synchronous exceptions first,
// then any pending (already IE/EXL/IM-qualified) interrupt.
module exc_prio_enc
  import cp0_pkg::*;
#(
  parameter int INT_NUM = 6
) (
  input  logic               i_sys,
  input  logic               i_bp,
  input  logic               i_ri,
  input  logic               i_ov,
  input  logic               i_dz,
  input  logic [INT_NUM-1:0] i_int_pend,
  output logic               o_trap_req,
  output logic [4:0]         o_code
);

  always_comb begin
    o_trap_req = 1'b1;
    o_code     = EXC_INT;
    if (i_sys)            o_code = EXC_SYS;
    else if (i_bp)        o_code = EXC_BP;
    else if (i_ri)        o_code = EXC_RI;
    else if (i_ov)        o_code = EXC_OV;
    else if (i_dz)        o_code = EXC_DZ;
    else if (|i_int_pend) o_code = EXC_INT;
    else                  o_trap_req = 1'b0;
  end

endmodule

// File: rtl/cp0_exc_ctrl.sv
// CP0 Status/Cause/EPC storage plus the trap/eret sequencer that flushes the
// pipeline and redirects fetch; only accepts events while IDLE.
module cp0_exc_ctrl
  import cp0_pkg::*;
#(
  parameter logic [31:0] HANDLER_ADDR = 32'h0000_F000,
  parameter int          INT_NUM      = 6
) (
  input  logic               clock,
  input  logic               reset,
  input  logic               exc_syscall,
  input  logic               exc_break,
  input  logic               exc_reserved,
  input  logic               exc_overflow,
  input  logic               exc_divzero,
  input  logic [INT_NUM-1:0] int_req,
  input  logic               eret,
  input  logic [31:0]        cur_pc,
  input  logic               mtc0,
  input  logic [4:0]         mfc0_mtc0_addr,
  input  logic [31:0]        mtc0_data,
  output logic [31:0]        cp0_rdata,
  output logic               busy,
  output logic               flush,
  output logic               redirect_valid,
  output logic [31:0]        redirect_pc,
  output logic [4:0]         exc_code
);

  cp0_state_e         r_state, w_state_nxt;
  logic               r_ie, r_exl;
  logic [INT_NUM-1:0] r_im, r_ip;
  logic [4:0]         r_exccode;
  logic [31:0]        r_epc;

  logic [INT_NUM-1:0] w_int_pend;
  logic               w_trap_req, w_idle, w_take_trap, w_take_eret, w_do_mtc0;
  logic [4:0]         w_code;
  logic [31:0]        w_status, w_cause;

  // Interrupts use the registered IP and are blocked inside a handler (EXL).
  assign w_int_pend = (r_ie && !r_exl) ? (r_ip & r_im) : '0;

  exc_prio_enc #(.INT_NUM(INT_NUM)) u_prio (
    .i_sys      (exc_syscall),
    .i_bp       (exc_break),
    .i_ri       (exc_reserved),
    .i_ov       (exc_overflow),
    .i_dz       (exc_divzero),
    .i_int_pend (w_int_pend),
    .o_trap_req (w_trap_req),
    .o_code     (w_code)
  );

  assign w_idle      = (r_state == IDLE);
  assign w_take_trap = w_idle && w_trap_req;
  assign w_take_eret = w_idle && !w_trap_req && eret;
  assign w_do_mtc0   = w_idle && !w_trap_req && !eret && mtc0;

  always_comb begin
    w_status                        = '0;
    w_status[ST_IE]                 = r_ie;
    w_status[ST_EXL]                = r_exl;
    w_status[ST_IM_LO +: INT_NUM]   = r_im;
    w_cause                         = '0;
    w_cause[CA_EXC_LO +: 5]         = r_exccode;
    w_cause[CA_IP_LO +: INT_NUM]    = r_ip;
  end

  always_comb begin
    case (mfc0_mtc0_addr)
      CP0_STATUS: cp0_rdata = w_status;
      CP0_CAUSE:  cp0_rdata = w_cause;
      CP0_EPC:    cp0_rdata = r_epc;
      default:    cp0_rdata = '0;
    endcase
  end

  assign exc_code = r_exccode;

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) r_state <= IDLE;
    else        r_state <= w_state_nxt;
  end

  always_comb begin
    w_state_nxt    = r_state;
    busy           = 1'b1;
    flush          = 1'b0;
    redirect_valid = 1'b0;
    redirect_pc    = '0;
    case (r_state)
      IDLE: begin
        busy = 1'b0;
        if (w_take_trap)      w_state_nxt = FLUSH;
        else if (w_take_eret) w_state_nxt = RETURN;
      end
      FLUSH: begin
        flush       = 1'b1;
        w_state_nxt = VECTOR;
      end
      VECTOR: begin
        redirect_valid = 1'b1;
        redirect_pc    = HANDLER_ADDR;
        w_state_nxt    = IDLE;
      end
      RETURN: begin
        redirect_valid = 1'b1;
        redirect_pc    = r_epc;
        flush          = 1'b1;
        w_state_nxt    = IDLE;
      end
      default: w_state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      r_ie      <= 1'b0;
      r_exl     <= 1'b0;
      r_im      <= '0;
      r_ip      <= '0;
      r_exccode <= '0;
      r_epc     <= '0;
    end else begin
      r_ip <= int_req;
      if (w_take_trap) begin
        r_epc     <= cur_pc;
        r_exccode <= w_code;
        r_exl     <= 1'b1;
      end else if (w_take_eret) begin
        r_exl <= 1'b0;
      end else if (w_do_mtc0) begin
        case (mfc0_mtc0_addr)
          CP0_STATUS: begin
            r_ie  <= mtc0_data[ST_IE];
            r_exl <= mtc0_data[ST_EXL];
            r_im  <= mtc0_data[ST_IM_LO +: INT_NUM];
          end
          CP0_EPC: r_epc <= mtc0_data;
          default: ;
        endcase
      end
    end
  end

endmodule
